// File: rtl/song_sequencer_if.sv
// Bus between the song sequencer and its environment: transport controls,
// song ROM port and the decoded note stream.
interface song_sequencer_if;
    logic        play;
    logic [1:0]  song;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        new_note;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic [2:0]  meta;
    logic        song_done;
    logic        busy;

    modport master (
        input  play, song, beat, rom_dout,
        output rom_addr, new_note, note, duration, meta, song_done, busy
    );

    modport slave (
        output play, song, beat, rom_dout,
        input  rom_addr, new_note, note, duration, meta, song_done, busy
    );
endinterface

// File: rtl/song_sequencer.sv
// Walks a 32-entry song in ROM, emitting note events and waiting on beat
// ticks for advance entries; end marker or index 31 completion ends the song.
module song_sequencer #(
    parameter bit LOOP = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    song_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  song_q, song_d;
    logic [4:0]  index_q, index_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  note_q, note_d;
    logic [5:0]  dur_q, dur_d;
    logic [2:0]  meta_q, meta_d;
    logic        new_note_q, new_note_d;
    logic        song_done_q, song_done_d;
    logic        last_q, last_d;    // index 31 completed; end of song on next FETCH
    logic        step_next;

    logic        e_adv;
    logic [5:0]  e_note;
    logic [5:0]  e_dur;
    logic [2:0]  e_meta;

    assign e_adv  = bus.rom_dout[15];
    assign e_note = bus.rom_dout[14:9];
    assign e_dur  = bus.rom_dout[8:3];
    assign e_meta = bus.rom_dout[2:0];

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        state_d     = state_q;
        song_d      = song_q;
        index_d     = index_q;
        cnt_d       = cnt_q;
        note_d      = note_q;
        dur_d       = dur_q;
        meta_d      = meta_q;
        last_d      = last_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;
        step_next   = 1'b0;

        if (state_q == IDLE) begin
            if (bus.play) begin
                song_d  = bus.song;
                index_d = '0;
                last_d  = 1'b0;
                state_d = FETCH;
            end
        end else if (bus.play) begin
            if (bus.song != song_q) begin
                song_d  = bus.song;
                index_d = '0;
                last_d  = 1'b0;
                state_d = FETCH;
            end else begin
                case (state_q)
                    FETCH: begin
                        if (last_q) begin
                            last_d      = 1'b0;
                            song_done_d = 1'b1;
                            state_d     = LOOP ? DECODE : IDLE;
                        end else begin
                            state_d = DECODE;
                        end
                    end
                    DECODE: begin
                        if (!e_adv) begin
                            note_d     = e_note;
                            dur_d      = e_dur;
                            meta_d     = e_meta;
                            new_note_d = 1'b1;
                            step_next  = 1'b1;
                        end else if (e_dur != 6'd0) begin
                            cnt_d   = e_dur;
                            state_d = WAIT;
                        end else begin
                            song_done_d = 1'b1;
                            index_d     = '0;
                            state_d     = LOOP ? FETCH : IDLE;
                        end
                    end
                    WAIT: begin
                        if (bus.beat) begin
                            if (cnt_q <= 6'd1) begin
                                cnt_d     = '0;
                                step_next = 1'b1;
                            end else begin
                                cnt_d = cnt_q - 6'd1;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // The 5-bit index wraps on its own; wrapping past 31 flags end of song.
        if (step_next) begin
            index_d = index_q + 5'd1;
            last_d  = (index_q == 5'd31);
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            song_q      <= '0;
            index_q     <= '0;
            cnt_q       <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            meta_q      <= '0;
            last_q      <= 1'b0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q     <= state_d;
            song_q      <= song_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            meta_q      <= meta_d;
            last_q      <= last_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    assign bus.rom_addr  = {song_q, index_q};
    assign bus.busy      = (state_q != IDLE);
    assign bus.new_note  = new_note_q;
    assign bus.song_done = song_done_q;
    assign bus.note      = note_q;
    assign bus.duration  = dur_q;
    assign bus.meta      = meta_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Randomized and directed bench for song_sequencer: a song-level model fills an
// event queue that a negedge monitor drains as pulses appear.
module tb_song_sequencer;

    typedef struct {
        bit         done;
        logic [5:0] n;
        logic [5:0] d;
        logic [2:0] m;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [15:0] rom [128];
    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          prev_nn = 1'b0;
    bit          prev_sd = 1'b0;

    song_sequencer_if bus ();

    song_sequencer #(.LOOP(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous song ROM: data valid one clock after the address.
    always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_note(logic [5:0] n, logic [5:0] d, logic [2:0] m);
        return {1'b0, n, d, m};
    endfunction

    function automatic logic [15:0] mk_adv(logic [5:0] d);
        return {1'b1, 6'd0, d, 3'd0};
    endfunction

    // Song-level model: the ordered events a song produces, independent of timing.
    task automatic push_song(input int s);
        ev_t e;
        logic [15:0] w;
        for (int i = 0; i < 32; i++) begin
            w = rom[32*s + i];
            if (!w[15]) begin
                e.done = 1'b0; e.n = w[14:9]; e.d = w[8:3]; e.m = w[2:0];
                exp_q.push_back(e);
            end else if (w[8:3] == 6'd0) begin
                e.done = 1'b1; e.n = '0; e.d = '0; e.m = '0;
                exp_q.push_back(e);
                return;
            end
        end
        e.done = 1'b1; e.n = '0; e.d = '0; e.m = '0;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic beat_pulse();
        bus.beat = 1'b1;
        step();
        bus.beat = 1'b0;
    endtask

    task automatic wait_pulse(input bit want_done, input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (want_done ? bus.song_done : bus.new_note) begin
                k = i;
                break;
            end
        end
    endtask

    // Monitor: every pulse is matched against the head of the expected queue.
    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            prev_nn = 1'b0;
            prev_sd = 1'b0;
        end else begin
            if (bus.new_note || bus.song_done) begin
                check("pulses exclusive", {31'd0, bus.new_note & bus.song_done}, 32'd0);
                check("new_note single cycle", {31'd0, bus.new_note & prev_nn}, 32'd0);
                check("song_done single cycle", {31'd0, bus.song_done & prev_sd}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected pulse: new_note=%0b song_done=%0b with empty queue",
                             bus.new_note, bus.song_done);
                end else begin
                    e = exp_q.pop_front();
                    check("event kind (1=done)", {31'd0, bus.song_done}, {31'd0, e.done});
                    if (!e.done) begin
                        check("note", {26'd0, bus.note}, {26'd0, e.n});
                        check("duration", {26'd0, bus.duration}, {26'd0, e.d});
                        check("meta", {29'd0, bus.meta}, {29'd0, e.m});
                    end
                end
            end
            prev_nn = bus.new_note;
            prev_sd = bus.song_done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " rom_addr"}, {25'd0, bus.rom_addr}, 32'd0);
        check({tag, " new_note"}, {31'd0, bus.new_note}, 32'd0);
        check({tag, " song_done"}, {31'd0, bus.song_done}, 32'd0);
        check({tag, " note"}, {26'd0, bus.note}, 32'd0);
        check({tag, " duration"}, {26'd0, bus.duration}, 32'd0);
        check({tag, " meta"}, {29'd0, bus.meta}, 32'd0);
    endtask

    initial begin
        int k;
        bit done_seen;
        logic [5:0] r;

        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0]  = mk_note(6'd52, 6'd12, 3'd1);
        rom[1]  = mk_note(6'd56, 6'd8, 3'd2);
        rom[2]  = mk_note(6'd59, 6'd4, 3'd3);
        rom[3]  = mk_adv(6'd12);
        rom[6]  = mk_note(6'd54, 6'd2, 3'd0);
        rom[12] = 16'h8000;
        rom[32] = mk_adv(6'd36);
        rom[33] = mk_note(6'd40, 6'd3, 3'd5);
        rom[34] = 16'h8000;
        rom[96] = 16'h8000;
        // Song 2: random notes and short advances, no end marker (ends at index 31).
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 6'($urandom_range(1, 3));
                rom[64 + i] = mk_adv(r);
            end else begin
                rom[64 + i] = 16'($urandom_range(0, 16'h7fff));
            end
        end

        reset    = 1'b1;
        bus.play = 1'b0;
        bus.song = 2'd0;
        bus.beat = 1'b0;
        repeat (3) step();
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (3) step();
        check("idle after reset busy", {31'd0, bus.busy}, 32'd0);

        // Song 0: three notes two cycles apart, first at N+3, then WAIT on index 3.
        bus.song = 2'd0;
        bus.play = 1'b1;
        push_song(0);
        wait_pulse(1'b0, 10, k); check("s0 first note latency", k, 3);
        wait_pulse(1'b0, 10, k); check("s0 note 2 spacing", k, 2);
        wait_pulse(1'b0, 10, k); check("s0 note 3 spacing", k, 2);
        repeat (4) step();
        check("s0 wait busy", {31'd0, bus.busy}, 32'd1);
        check("s0 wait rom_addr", {25'd0, bus.rom_addr}, 32'd3);
        repeat (11) beat_pulse();
        repeat (3) step();
        check("s0 after 11 beats rom_addr", {25'd0, bus.rom_addr}, 32'd3);
        beat_pulse();
        check("s0 12th beat fetches index 4", {25'd0, bus.rom_addr}, 32'd4);
        wait_pulse(1'b0, 10, k); check("s0 index 4 latency", k, 2);
        for (int i = 0; i < 7; i++) begin
            wait_pulse(1'b0, 10, k); check("s0 note spacing", k, 2);
        end
        wait_pulse(1'b1, 10, k); check("s0 end marker latency", k, 2);
        bus.play = 1'b0;
        step();
        check("s0 idle after done", {31'd0, bus.busy}, 32'd0);

        // Song 1: 36-beat advance with a 10-cycle pause in the middle.
        bus.song = 2'd1;
        bus.play = 1'b1;
        push_song(1);
        repeat (3) step();
        repeat (20) beat_pulse();
        bus.play = 1'b0;
        bus.beat = 1'b1;
        repeat (10) step();
        check("s1 paused busy", {31'd0, bus.busy}, 32'd1);
        check("s1 paused rom_addr", {25'd0, bus.rom_addr}, 32'd32);
        bus.beat = 1'b0;
        bus.play = 1'b1;
        repeat (15) beat_pulse();
        step();
        check("s1 after 35 beats rom_addr", {25'd0, bus.rom_addr}, 32'd32);
        beat_pulse();
        check("s1 36th beat fetches 33", {25'd0, bus.rom_addr}, 32'd33);
        wait_pulse(1'b0, 10, k); check("s1 note latency", k, 2);
        wait_pulse(1'b1, 10, k); check("s1 done latency", k, 2);
        bus.play = 1'b0;
        step();
        check("s1 idle after done", {31'd0, bus.busy}, 32'd0);

        // Song 3: immediate end marker.
        bus.song = 2'd3;
        bus.play = 1'b1;
        push_song(3);
        wait_pulse(1'b1, 10, k); check("s3 done latency", k, 3);
        bus.play = 1'b0;
        step();
        check("s3 idle after done", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset mid-WAIT.
        bus.song = 2'd0;
        bus.play = 1'b1;
        push_song(0);
        repeat (3) wait_pulse(1'b0, 10, k);
        repeat (4) step();
        #1;
        reset    = 1'b1;
        bus.play = 1'b0;
        #1;
        check_outputs_zero("mid-wait reset");
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        check("idle after mid-wait reset", {31'd0, bus.busy}, 32'd0);

        // Song change 0 -> 2 mid-song: restart at 64, no song_done for song 0.
        bus.song = 2'd0;
        bus.play = 1'b1;
        push_song(0);
        repeat (3) wait_pulse(1'b0, 10, k);
        repeat (4) step();
        exp_q.delete();
        push_song(2);
        bus.song = 2'd2;
        step();
        check("abort fetch address", {25'd0, bus.rom_addr}, 32'd64);
        check("abort busy", {31'd0, bus.busy}, 32'd1);

        // Song 2 runs with random beats and random pauses until it ends.
        done_seen = 1'b0;
        for (int i = 0; i < 4000 && !done_seen; i++) begin
            bus.beat = 1'($urandom_range(0, 1));
            bus.play = ($urandom_range(0, 7) != 0);
            step();
            if (bus.song_done) done_seen = 1'b1;
        end
        bus.play = 1'b0;
        bus.beat = 1'b0;
        check("s2 reached end", {31'd0, done_seen}, 32'd1);
        repeat (3) step();
        check("s2 idle after done", {31'd0, bus.busy}, 32'd0);
        check("expected queue drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 The block SHALL have one parameter: LOOP, default 0, where 1 means restart the song at its end instead of stopping.
REQ-002 The block SHALL have the following ports:
  clk  in  1  system clock; all state changes on its rising edge.
  reset  in  1  asynchronous reset, active-high.
  play  in  1  level; 1 = run, 0 = pause.
  song  in  2  song select; song s occupies ROM addresses 32*s .. 32*s+31.
  beat  in  1  one-cycle beat tick from the beat generator.
  rom_addr  out  7  song ROM address, {song_q, index[4:0]}.
  rom_dout  in  16  song ROM data; valid one clk after rom_addr.
  new_note  out  1  one-cycle pulse; note, duration and meta are valid in that cycle.
  note  out  6  note number; 0 = rest.
  duration  out  6  note length in beats.
  meta  out  3  entry metadata bits.
  song_done  out  1  one-cycle pulse at the end of the song.
  busy  out  1  1 whenever the FSM is not in IDLE.
REQ-003 Entry format SHALL be: bit15 = adv, bits14:9 = note, bits8:3 = dur, bits2:0 = meta.

Function
REQ-004 The FSM SHALL have the states IDLE, FETCH, DECODE and WAIT.
REQ-005 IDLE behaviour:
- If play=1, latch song into song_q, set index=0, go to FETCH.
- Otherwise stay in IDLE.
REQ-006 FETCH SHALL last exactly one cycle (ROM latency) and then go to DECODE.
REQ-007 DECODE with adv=0 (note entry):
- Register note/dur/meta into note/duration/meta.
- Pulse new_note in the following cycle.
- Advance index and go to FETCH.
REQ-008 DECODE with adv=1 and dur≠0 (advance entry):
- Load the beat counter with dur and go to WAIT.
- Ignore the note and meta fields; do not pulse new_note.
REQ-009 DECODE with adv=1 and dur=0 SHALL be the end marker: pulse song_done, then go to IDLE (LOOP=0) or to FETCH with index=0 (LOOP=1).
REQ-010 In WAIT, each beat SHALL decrement the counter; the beat that takes the counter from 1 to 0 SHALL advance index and go to FETCH.
REQ-011 Completing index 31 without an end marker SHALL be treated as end of song, behaving as in REQ-009.
REQ-012 Index SHALL be 5 bits and SHALL never carry into song_q.
REQ-013 rom_addr SHALL be driven from registered song_q and index only.
REQ-014 Pause (play=0 while busy):
- FSM holds its state, index and counter.
- Beats are ignored; no pulses are generated.
- rom_addr is held, so rom_dout stays valid and DECODE resumes correctly.
REQ-015 If song≠song_q while busy and play=1, the FSM SHALL abort: latch the new song, set index=0, go to FETCH, and not pulse song_done.
REQ-016 A song change SHALL take priority over a beat or DECODE action in the same cycle.
REQ-017 note/duration/meta SHALL hold their last value until the next new_note.
REQ-018 Latency: play sampled high in IDLE at edge N -> FETCH at N+1 -> DECODE at N+2 -> new_note high in cycle N+3.
REQ-019 Back-to-back note entries SHALL produce new_note pulses every 2 cycles.
REQ-020 new_note and song_done SHALL never be high for two consecutive cycles, and SHALL never be high together.

Reset
REQ-021 Assertion of reset SHALL, asynchronously and in any state including mid-WAIT:
- Force state to IDLE.
- Clear index, song_q and the beat counter.
- Set rom_addr=0, note=0, duration=0, meta=0.
- Set new_note=0, song_done=0, busy=0.
REQ-022 After reset deasserts, the block SHALL stay in IDLE until play is sampled high.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- Play song 0 with beat=0 -> new_note pulses with 52/12, 56/8, 59/4, each 2 cycles apart (first at N+3); then WAIT with counter=12, busy=1.
- Continue song 0: send 12 beats -> one cycle after the 12th beat the FSM fetches index 4 -> 7 idle entries yield note-0 pulses; index 6 yields note 54/2.
- Play song 3 (entry 96 = end marker), LOOP=0 -> song_done pulse in cycle N+3, no new_note, busy=0 afterwards.
- Play song 1 -> entry 32 is an advance of 36 beats -> no new_note; exactly 36 beats elapse before the fetch of address 33.
- Deassert play mid-WAIT for 10 cycles while driving beats -> counter unchanged; resume and finish with the correct remaining count.
- Assert reset mid-WAIT -> all outputs zero immediately; switch song 0 -> 2 mid-song -> the next fetch is address 64 with no song_done pulse.
